// File: rtl/rgb_to_yuv_pkg.sv
// Shared definitions for the RGB to 4:2:2 YUV encoder: FSM state codes,
// conversion coefficients and the signed chroma averaging helper.
package rgb_to_yuv_pkg;

    typedef enum logic [3:0] {
        S_P0  = 4'd0,
        S_P1  = 4'd1,
        S_OU  = 4'd2,
        S_OY0 = 4'd3,
        S_OV  = 4'd4,
        S_OY1 = 4'd5
    } state_t;

    localparam logic [7:0] KY_R = 8'd74;
    localparam logic [7:0] KY_G = 8'd162;
    localparam logic [7:0] KY_B = 8'd20;
    localparam logic [7:0] KV   = 8'd158;
    localparam logic [7:0] RND  = 8'd128;

    // Rounded mean of two signed 8-bit chroma values; 9 bits hold the sum without overflow.
    function automatic logic [7:0] avg_round(input logic [7:0] a, input logic [7:0] b);
        logic signed [8:0] s;
        s = $signed({a[7], a}) + $signed({b[7], b}) + 9'sd1;
        return 8'(s >>> 1);
    endfunction

endpackage

// File: rtl/rgb_to_yuv_pixel.sv
// Combinational per-pixel converter: {R,G,B} -> {Y, U, V}, with U/V in two's complement.
module rgb_to_yuv_pixel
    import rgb_to_yuv_pkg::*;
(
    input  logic [23:0] i_rgb,
    output logic [23:0] o_yuv
);

    logic [7:0]         w_r;
    logic [7:0]         w_g;
    logic [7:0]         w_b;
    logic [7:0]         w_y;
    logic [17:0]        w_y_sum;
    logic signed [9:0]  w_u_diff;
    logic signed [8:0]  w_r_minus_y;
    logic signed [18:0] w_v_sum;

    assign {w_r, w_g, w_b} = i_rgb;

    // Luma coefficients sum to 256, so the shifted result always fits in 8 bits.
    assign w_y_sum = 18'(w_r) * 18'(KY_R) + 18'(w_g) * 18'(KY_G)
                   + 18'(w_b) * 18'(KY_B) + 18'(RND);
    assign w_y     = 8'(w_y_sum >> 8);

    assign w_u_diff    = $signed({2'b00, w_b}) - $signed({2'b00, w_y}) + 10'sd1;
    assign w_r_minus_y = $signed({1'b0, w_r}) - $signed({1'b0, w_y});
    assign w_v_sum     = $signed({{10{w_r_minus_y[8]}}, w_r_minus_y}) * $signed({11'd0, KV})
                       + $signed({11'd0, RND});

    assign o_yuv = {w_y, 8'(w_u_diff >>> 1), 8'(w_v_sum >>> 8)};

endmodule

// File: rtl/rgb_to_yuv.sv
// RGB pixel pairs in, byte-serial U, Y0, V, Y1 out. One shared pixel converter;
// the last output byte overlaps with accepting the next pair's first pixel.
module rgb_to_yuv
    import rgb_to_yuv_pkg::*;
#(
    parameter int CHROMA_AVG = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_en,
    input  logic [23:0] rgb_in,
    output logic        busy,
    output logic        out_valid,
    output logic [7:0]  yuv_out
);

    state_t      r_state;
    state_t      w_state_next;
    logic        w_accept;
    logic [23:0] w_pix;
    logic [7:0]  r_y0;
    logic [7:0]  r_u0;
    logic [7:0]  r_v0;
    logic [7:0]  r_y1;
    logic [7:0]  r_u;
    logic [7:0]  r_v;
    logic [7:0]  w_c0   [2];
    logic [7:0]  w_c1   [2];
    logic [7:0]  w_cmix [2];

    rgb_to_yuv_pixel u_pixel (
        .i_rgb (rgb_in),
        .o_yuv (w_pix)
    );

    assign w_accept = reset & in_en & ~busy;

    assign w_c0[0] = r_u0;
    assign w_c0[1] = r_v0;
    assign w_c1[0] = w_pix[15:8];
    assign w_c1[1] = w_pix[7:0];

    // Index 0 is U, index 1 is V.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chroma
            if (CHROMA_AVG != 0) begin : g_avg
                assign w_cmix[gi] = avg_round(w_c0[gi], w_c1[gi]);
            end else begin : g_pick
                assign w_cmix[gi] = w_c0[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_P0;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = S_P0;
        case (r_state)
            S_P0:    w_state_next = w_accept ? S_P1 : S_P0;
            S_P1:    w_state_next = w_accept ? S_OU : S_P1;
            S_OU:    w_state_next = S_OY0;
            S_OY0:   w_state_next = S_OV;
            S_OV:    w_state_next = S_OY1;
            S_OY1:   w_state_next = w_accept ? S_P1 : S_P0;
            default: w_state_next = S_P0;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        out_valid = 1'b0;
        yuv_out   = 8'h00;
        case (r_state)
            S_P0, S_P1: ;
            S_OU:  begin busy = 1'b1; out_valid = 1'b1; yuv_out = r_u;  end
            S_OY0: begin busy = 1'b1; out_valid = 1'b1; yuv_out = r_y0; end
            S_OV:  begin busy = 1'b1; out_valid = 1'b1; yuv_out = r_v;  end
            S_OY1: begin              out_valid = 1'b1; yuv_out = r_y1; end
            default: busy = 1'b1;
        endcase
    end

    // Pixel 1 lands in S_P1; every other accept (S_P0 or S_OY1) is a fresh pixel 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_y0 <= 8'h00;
            r_u0 <= 8'h00;
            r_v0 <= 8'h00;
            r_y1 <= 8'h00;
            r_u  <= 8'h00;
            r_v  <= 8'h00;
        end else if (w_accept) begin
            if (r_state == S_P1) begin
                r_y1 <= w_pix[23:16];
                r_u  <= w_cmix[0];
                r_v  <= w_cmix[1];
            end else begin
                r_y0 <= w_pix[23:16];
                r_u0 <= w_pix[15:8];
                r_v0 <= w_pix[7:0];
            end
        end
    end

endmodule

// File: doc/rgb_to_yuv.md
# rgb_to_yuv

Converts a stream of 24-bit RGB pixels into the byte-serial 4:2:2 YUV stream U, Y0, V, Y1 that the CTE YUV-to-RGB path consumes. It is the encode direction for CTE `op_mode=1`, and it drives `yuv_out`/`out_valid`/`busy` in that mode. Each accepted pixel pair produces one 4-byte group.

## Interface
- `CHROMA_AVG`, default 1: 1 = U/V are the rounded mean of both pixels' chroma; 0 = U/V are taken from pixel 0 only.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous reset, active low.
- `in_en`  in  1: `rgb_in` is valid this cycle.
- `rgb_in`  in  24: pixel as {R[23:16], G[15:8], B[7:0]}, unsigned.
- `busy`  out  1: high means `rgb_in` is not accepted this cycle.
- `out_valid`  out  1: `yuv_out` carries a valid byte this cycle.
- `yuv_out`  out  8: Y is unsigned; U and V are two's complement.

## Operation
- **Accept rule:** a pixel is accepted on a rising edge where `reset=1`, `in_en=1` and `busy=0`.
- **Per-pixel conversion (combinational on `rgb_in`, integer arithmetic, `>>>` is arithmetic shift):**
  - Y = (74R + 162G + 20B + 128) >> 8. Coefficients sum to 256, so Y is in 0..255 and needs no clamp.
  - U = (B − Y + 1) >>> 1. Range −117..118.
  - V = ((R − Y)·158 + 128) >>> 8. Range −112..112.
  - Neither U nor V needs saturation. The verification bench asserts these ranges.
- **Pair combine:**
  - `CHROMA_AVG=1`: U = (U0 + U1 + 1) >>> 1 and V = (V0 + V1 + 1) >>> 1, using 9-bit signed intermediates.
  - `CHROMA_AVG=0`: U = U0 and V = V0.
- **State machine** (4-bit state):
  - S_P0: `busy=0`. On accept, store Y0/U0/V0 and go to S_P1. Otherwise stay.
  - S_P1: `busy=0`. On accept, store Y1 and the final U/V, then go to S_OU. Otherwise stay. There is no timeout; `in_en` may stay low indefinitely.
  - S_OU: `yuv_out=U`, `out_valid=1`, `busy=1`. Go to S_OY0.
  - S_OY0: `yuv_out=Y0`, `out_valid=1`, `busy=1`. Go to S_OV.
  - S_OV: `yuv_out=V`, `out_valid=1`, `busy=1`. Go to S_OY1.
  - S_OY1: `yuv_out=Y1`, `out_valid=1`, `busy=0`. If a pixel is accepted, it becomes the new pixel 0 and the state goes to S_P1; otherwise go to S_P0.
  - Illegal state codes go to S_P0 on the next edge.
- **Outputs outside S_OU..S_OY1:** `yuv_out=8'h00` and `out_valid=0`.
- There is no output backpressure. A group, once started, always completes its 4 bytes.

## Timing
- **Reset:** with `reset=0` at an edge, state → S_P0 and all stored Y/U/V registers → 0. After that edge `busy=0`, `out_valid=0`, `yuv_out=0`.
- **Reset mid-group:** the partial group is dropped and no further bytes are emitted.
- **Latency:** pixel 1 accepted at edge k → U is visible in cycle k+1, Y0 in k+2, V in k+3, Y1 in k+4.
- **Throughput:** best case is 2 pixels per 5 cycles, because S_OY1 overlaps with accepting the next pixel 0.
- **Simultaneous events:** `in_en=1` during S_OU..S_OV is ignored, and the upstream must hold the pixel. `in_en=1` in S_OY1 is accepted.
- **Output registering:** `out_valid`, `busy` and `yuv_out` are decoded from registered state and data only. No combinational path runs from any input to any output.

## Structure
- **Package `rgb_to_yuv_pkg`:** state encodings (S_P0=0 .. S_OY1=5), coefficients (KY_R=74, KY_G=162, KY_B=20, KV=158) and the rounding constant 128.
- **Sub-module `rgb_to_yuv_pixel`:** purely combinational, `rgb_in` → {Y[7:0], U[7:0], V[7:0]}. The top-level instantiates it exactly once and shares it between pixel 0 and pixel 1.

## Test plan
- **Reset value:** hold `reset=0` for 2 cycles with `in_en=1` → `busy=0`, `out_valid=0`, `yuv_out=00` throughout.
- **Same-colour pairs:**
  - White pair (FFFFFF, FFFFFF) → 00, FF, 00, FF.
  - Black pair (000000, 000000) → 00, 00, 00, 00.
  - In both cases `out_valid` is high for exactly 4 cycles, starting the cycle after pixel 1.
- **Single primaries:**
  - Red pair (FF0000 ×2) → DB, 4A, 70, 4A.
  - Green pair (00FF00 ×2) → B0, A1, 9D, A1.
  - Blue pair (0000FF ×2) → 76, 14, F4, 14.
- **Chroma mix:**
  - (FF0000, 0000FF) with `CHROMA_AVG=1` → 29, 4A, 32, 14.
  - Same pair with `CHROMA_AVG=0` → DB, 4A, 70, 14.
- **Back-to-back and held input:**
  - Continuous `in_en=1` → `busy` pattern 0,0,1,1,1,0 repeats with a 5-cycle period, and every pixel is used exactly once.
  - `in_en=0` for 10 cycles in S_P1 → no output; the pair completes once the pixel arrives.
- **Reset mid-group:**
  - Assert `reset=0` during the V byte → the next cycle shows `out_valid=0` and `yuv_out=00`.
  - The next pair after reset produces a correct, complete group.
